aoc3_line_ctrl: RTL

Sequencer that sits between a raw ASCII byte stream and the day-3 digit-selection datapath (`top`, `line_length`/`MAX_CAP` parameterised). It converts digit characters into datapath beats and drives the per-line drain (newline) window. It captures each line result, accumulates the running answer, and issues a one-cycle per-line clear. This removes the per-line sequencing and reset pulsing from the bench so the whole input file runs as one streamed transaction.

---
 rtl/aoc3_line_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/aoc3_line_ctrl.sv
// aoc3_line_ctrl: per-line sequencer in front of the day-3 digit-selection datapath.
// Turns an ASCII byte stream into digit beats, drives the drain window after each
// line, captures the line result into a running sum and pulses a per-line clear.
module aoc3_line_ctrl #(
  parameter int LINE_LENGTH = 15,
  parameter int MAX_CAP     = 12,
  parameter int TIMEOUT     = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int SUM_WIDTH   = 2 * DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_byte,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] dp_data_in,
  output logic                  dp_data_in_valid,
  output logic                  dp_newline,
  output logic                  dp_clear,
  input  logic [SUM_WIDTH-1:0]  dp_data_out,
  input  logic                  dp_data_out_valid,
  output logic [SUM_WIDTH-1:0]  cum_sum,
  output logic [15:0]           line_count,
  output logic                  done,
  output logic                  err_overflow,
  output logic                  err_timeout,
  output logic                  err_char,
  output logic                  sum_ovf
);

  localparam int DCW = $clog2(LINE_LENGTH + 1);
  localparam int CW  = $clog2(MAX_CAP + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [DCW-1:0] DCNT_MAX   = DCW'(LINE_LENGTH);
  localparam logic [CW-1:0]  DRAIN_LAST = CW'(MAX_CAP - 1);
  localparam logic [TW-1:0]  TMO_LAST   = TW'(TIMEOUT - 1);

  localparam logic [2:0] ST_STREAM  = 3'd0;
  localparam logic [2:0] ST_DRAIN   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_CLEAR   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]       state_r;
  logic [DCW-1:0]   dcnt_r;
  logic [CW-1:0]    drain_cnt_r;
  logic [TW-1:0]    tmo_cnt_r;
  logic             last_pend_r;

  logic             accept_s;
  logic             is_digit_s;
  logic             is_lf_s;
  logic             digit_ok_s;
  logic [DCW-1:0]   dcnt_next_s;
  logic [SUM_WIDTH:0] sum_ext_s;

  // Byte classification and the look-ahead digit count used by the in_last decision.
  always_comb begin
    accept_s    = in_valid && in_ready;
    is_digit_s  = (in_byte >= 8'h30) && (in_byte <= 8'h39);
    is_lf_s     = (in_byte == 8'h0A);
    digit_ok_s  = is_digit_s && (dcnt_r < DCNT_MAX);
    if (digit_ok_s) begin
      dcnt_next_s = dcnt_r + DCW'(1);
    end else begin
      dcnt_next_s = dcnt_r;
    end
    sum_ext_s = {1'b0, cum_sum} + {1'b0, dp_data_out};
  end

  // Line sequencer: all outputs are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r          <= ST_STREAM;
      dcnt_r           <= '0;
      drain_cnt_r      <= '0;
      tmo_cnt_r        <= '0;
      last_pend_r      <= 1'b0;
      in_ready         <= 1'b1;
      dp_data_in       <= '0;
      dp_data_in_valid <= 1'b0;
      dp_newline       <= 1'b0;
      dp_clear         <= 1'b0;
      cum_sum          <= '0;
      line_count       <= 16'd0;
      done             <= 1'b0;
      err_overflow     <= 1'b0;
      err_timeout      <= 1'b0;
      err_char         <= 1'b0;
      sum_ovf          <= 1'b0;
    end else begin
      dp_data_in_valid <= 1'b0;
      dp_clear         <= 1'b0;
      case (state_r)
        ST_STREAM: begin
          if (accept_s) begin
            if (is_digit_s) begin
              if (digit_ok_s) begin
                // '0'..'9' carry their value in the low nibble
                dp_data_in       <= {{(DATA_WIDTH-4){1'b0}}, in_byte[3:0]};
                dp_data_in_valid <= 1'b1;
                dcnt_r           <= dcnt_next_s;
              end else begin
                err_overflow <= 1'b1;
              end
            end else if (!is_lf_s) begin
              err_char <= 1'b1;
            end
            if (in_last) begin
              last_pend_r <= 1'b1;
              in_ready    <= 1'b0;
              if (dcnt_next_s != '0) begin
                // a final digit beat goes out first, so the drain window starts a cycle later
                state_r     <= ST_DRAIN;
                drain_cnt_r <= '0;
                dp_newline  <= !digit_ok_s;
              end else begin
                state_r <= ST_DONE;
                done    <= 1'b1;
              end
            end else if (is_lf_s && (dcnt_r != '0)) begin
              state_r     <= ST_DRAIN;
              in_ready    <= 1'b0;
              drain_cnt_r <= '0;
              dp_newline  <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (!dp_newline) begin
            dp_newline <= 1'b1;
          end else if (drain_cnt_r == DRAIN_LAST) begin
            dp_newline <= 1'b0;
            tmo_cnt_r  <= '0;
            state_r    <= ST_CAPTURE;
          end else begin
            drain_cnt_r <= drain_cnt_r + CW'(1);
          end
        end
        ST_CAPTURE: begin
          if (dp_data_out_valid) begin
            cum_sum  <= sum_ext_s[SUM_WIDTH-1:0];
            sum_ovf  <= sum_ovf | sum_ext_s[SUM_WIDTH];
            if (line_count != 16'hFFFF) begin
              line_count <= line_count + 16'd1;
            end else begin
              line_count <= line_count;
            end
            dp_clear <= 1'b1;
            state_r  <= ST_CLEAR;
          end else if (tmo_cnt_r == TMO_LAST) begin
            err_timeout <= 1'b1;
            dp_clear    <= 1'b1;
            state_r     <= ST_CLEAR;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
        ST_CLEAR: begin
          dcnt_r <= '0;
          if (last_pend_r) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
          end else begin
            state_r  <= ST_STREAM;
            in_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          in_ready <= 1'b0;
          done     <= 1'b1;
        end
        default: begin
          state_r    <= ST_STREAM;
          in_ready   <= 1'b1;
          dp_newline <= 1'b0;
        end
      endcase
    end
  end

endmodule
